// File: rtl/div_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : div_unit_if                                               |
// | Brief    : Request/result bundle between the EX stage and div_unit.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface div_unit_if;
  logic [31:0] div_data1_i;
  logic [31:0] div_data2_i;
  logic        div_signed_i;
  logic        div_start_i;
  logic [63:0] div_result_o;
  logic        div_done_o;

  modport master (
    output div_data1_i, div_data2_i, div_signed_i, div_start_i,
    input  div_result_o, div_done_o
  );

  modport slave (
    input  div_data1_i, div_data2_i, div_signed_i, div_start_i,
    output div_result_o, div_done_o
  );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : div_unit                                                  |
// | Brief    : 32-bit iterative restoring divider, one quotient bit per  |
// |            cycle; result = {remainder, quotient}.                    |
// |            Optional macro DIV_ZERO_SHORTCUT_EN: divide-by-zero goes  |
// |            straight from IDLE to DONE.                               |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module div_unit (
  input  wire logic   clk,
  input  wire logic   rst,
  div_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic        r_q_neg;
  logic        r_r_neg;
  logic [63:0] r_result;
  logic        r_done;

  logic        w_load;
  logic        w_step;
  logic        w_finish;
  logic        w_short;
  logic        w_release;

  logic [31:0] w_mag1;
  logic [31:0] w_mag2;
  logic [32:0] w_partial;
  logic        w_ge;
  logic [31:0] w_rem_step;
  logic [31:0] w_quo_step;
  logic [31:0] w_rem_fix;
  logic [31:0] w_quo_fix;
  logic [63:0] w_final;
  logic        w_last;

  assign w_mag1 = (bus.div_signed_i && bus.div_data1_i[31]) ? (~bus.div_data1_i + 32'd1)
                                                            : bus.div_data1_i;
  assign w_mag2 = (bus.div_signed_i && bus.div_data2_i[31]) ? (~bus.div_data2_i + 32'd1)
                                                            : bus.div_data2_i;

  // Dividend bits shift out of r_quo into the partial remainder as quotient bits shift in.
  assign w_partial  = {r_rem, r_quo[31]};
  assign w_ge       = (w_partial >= {1'b0, r_dvs});
  assign w_rem_step = w_ge ? (w_partial[31:0] - r_dvs) : w_partial[31:0];
  assign w_quo_step = {r_quo[30:0], w_ge};
  assign w_last     = (r_cnt == 6'd31);

  // With a zero divisor every step subtracts nothing, so the remainder ends as the
  // dividend magnitude and the sign fixup restores the original dividend.
  assign w_rem_fix = r_r_neg ? (~w_rem_step + 32'd1) : w_rem_step;
  assign w_quo_fix = r_q_neg ? (~w_quo_step + 32'd1) : w_quo_step;
  assign w_final   = {w_rem_fix, (r_dvs == 32'd0) ? 32'hFFFF_FFFF : w_quo_fix};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    w_short     = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.div_start_i) begin
          w_load = 1'b1;
`ifdef DIV_ZERO_SHORTCUT_EN
          if (bus.div_data2_i == 32'd0) begin
            w_short     = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_CALC;
          end
`else
          w_state_nxt = S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (!bus.div_start_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_step = 1'b1;
          if (w_last) begin
            w_finish    = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!bus.div_start_i) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= 6'd0;
      r_rem    <= 32'd0;
      r_quo    <= 32'd0;
      r_dvs    <= 32'd0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_result <= 64'd0;
      r_done   <= 1'b0;
    end else begin
      if (w_load) begin
        r_quo   <= w_mag1;
        r_dvs   <= w_mag2;
        r_rem   <= 32'd0;
        r_cnt   <= 6'd0;
        r_q_neg <= bus.div_signed_i & (bus.div_data1_i[31] ^ bus.div_data2_i[31]);
        r_r_neg <= bus.div_signed_i & bus.div_data1_i[31];
      end
      if (w_step) begin
        r_rem <= w_rem_step;
        r_quo <= w_quo_step;
        r_cnt <= r_cnt + 6'd1;
      end
      if (w_finish) begin
        r_result <= w_final;
        r_done   <= 1'b1;
      end
      if (w_short) begin
        r_result <= {bus.div_data1_i, 32'hFFFF_FFFF};
        r_done   <= 1'b1;
      end
      if (w_release) r_done <= 1'b0;
    end
  end

  assign bus.div_result_o = r_result;
  assign bus.div_done_o   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_div_unit                                               |
// | Brief    : Scoreboard bench for div_unit (reference model + queue).  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [63:0] exp_q[$];

`ifdef DIV_ZERO_SHORTCUT_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 33;
`endif

  div_unit_if bus();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction

  // Issue one request, hold start 'hold' cycles past done, then release.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int exp_lat, input int hold, input string tag);
    int t0, lat;
    logic [63:0] e;
    @(negedge clk);
    bus.div_data1_i  = a;
    bus.div_data2_i  = b;
    bus.div_signed_i = s;
    bus.div_start_i  = 1'b1;
    exp_q.push_back(model(a, b, s));
    t0  = cyc;
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.div_data1_i  = $urandom;
        bus.div_data2_i  = $urandom;
        bus.div_signed_i = ~s;
      end
      if (bus.div_done_o) begin
        lat = cyc - t0;
        break;
      end
    end
    e = exp_q.pop_front();
    if (lat < 0) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_res"}, bus.div_result_o, e);
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk({tag, "_hold_done"}, 64'(bus.div_done_o), 64'd1);
        chk({tag, "_hold_res"}, bus.div_result_o, e);
      end
    end
    bus.div_start_i = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_done"}, 64'(bus.div_done_o), 64'd0);
    chk({tag, "_idle_res"}, bus.div_result_o, e);
  endtask

  initial begin
    int ones;
    logic [63:0] prev;
    logic [31:0] ra, rb;
    bus.div_data1_i  = 32'd0;
    bus.div_data2_i  = 32'd0;
    bus.div_signed_i = 1'b0;
    bus.div_start_i  = 1'b0;
    #1;
    chk("rst_done", 64'(bus.div_done_o), 64'd0);
    chk("rst_res", bus.div_result_o, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, 33, 0, "u100_7");
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 33, 0, "sm7_2");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 0, "s_ovf");
    run_op(32'h1234_5678, 32'd0, 1'b0, ZERO_LAT, 0, "u_div0");
    run_op(32'h1234_5678, 32'd0, 1'b1, ZERO_LAT, 0, "s_div0");
    run_op(32'h8765_4321, 32'd0, 1'b1, ZERO_LAT, 0, "sneg_div0");
    run_op(32'h8765_4321, 32'hFFFF_FFFD, 1'b1, 33, 0, "s_negneg");

    // Cancel at cycle 10: no done, result keeps last completed value.
    prev = bus.div_result_o;
    @(negedge clk);
    bus.div_data1_i  = 32'd50;
    bus.div_data2_i  = 32'd5;
    bus.div_signed_i = 1'b0;
    bus.div_start_i  = 1'b1;
    repeat (10) @(negedge clk);
    bus.div_start_i = 1'b0;
    ones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.div_done_o) ones++;
    end
    chk("cancel_done", 64'(ones), 64'd0);
    chk("cancel_res", bus.div_result_o, prev);
    run_op(32'd9, 32'd3, 1'b0, 33, 0, "u9_3");

    // Reset at cycle 20 of an operation.
    @(negedge clk);
    bus.div_data1_i = 32'd1000;
    bus.div_data2_i = 32'd3;
    bus.div_start_i = 1'b1;
    repeat (20) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_done", 64'(bus.div_done_o), 64'd0);
    chk("arst_res", bus.div_result_o, 64'd0);
    bus.div_start_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.div_done_o) ones++;
    end
    chk("arst_nodone", 64'(ones), 64'd0);

    run_op(32'd100, 32'd7, 1'b0, 33, 3, "hold3");

    for (int n = 0; n < 6; n++) begin
      ra = $urandom;
      rb = $urandom >> (n * 5);
      if (rb == 32'd0) rb = 32'd1;
      run_op(ra, rb, n[0], 33, 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL provide ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL provide ports: rst  in  1  asynchronous active-low reset; low forces reset state immediately, independent of clk.
REQ-003 SHALL provide ports: div_data1_i  in  32  dividend.
REQ-004 SHALL provide ports: div_data2_i  in  32  divisor.
REQ-005 SHALL provide ports: div_signed_i  in  1  1 = signed (div.w/mod.w), 0 = unsigned (div.wu/mod.wu).
REQ-006 SHALL provide ports: div_start_i  in  1  level request, held high by EX while it stalls; low = cancel/idle.
REQ-007 SHALL provide ports: div_result_o  out  64  {remainder[63:32], quotient[31:0]}, registered.
REQ-008 SHALL provide ports: div_done_o  out  1  result valid, registered.

Function
REQ-009 SHALL implement FSM states IDLE, CALC, DONE.
REQ-010 IDLE: SHALL latch operands and div_signed_i and enter CALC when div_start_i=1; otherwise stay IDLE.
REQ-011 SHALL convert signed operands to magnitudes on latch; 0x80000000 magnitude = 0x80000000 (unsigned).
REQ-012 CALC: SHALL perform one restoring radix-2 step per cycle, MSB first, with a 6-bit counter; exactly 32 steps, then enter DONE.
REQ-013 SHALL ignore div_data1_i/div_data2_i/div_signed_i changes after latch.
REQ-014 Signed fixup: SHALL negate quotient when dividend and divisor signs differ; remainder SHALL take the dividend's sign.
REQ-015 Overflow 0x80000000 / 0xFFFFFFFF signed: SHALL yield quotient 0x80000000, remainder 0x00000000.
REQ-016 Divisor zero: SHALL yield quotient 0xFFFFFFFF, remainder = original dividend, signed or unsigned.
REQ-017 DONE: SHALL drive div_done_o=1 with the final div_result_o; return to IDLE on the first edge where div_start_i=0, else stay DONE with outputs held.
REQ-018 Latency: div_done_o SHALL be high in cycle 33 after the cycle in which div_start_i is first sampled high in IDLE (cycle 0).
REQ-019 Cancel: div_start_i=0 in CALC SHALL return to IDLE on the next edge without asserting div_done_o or updating div_result_o.
REQ-020 div_done_o SHALL be 0 in IDLE and CALC; div_result_o SHALL hold its last completed value outside DONE.
REQ-021 A new request SHALL be accepted no earlier than the first IDLE cycle after DONE (no back-to-back without one IDLE cycle).

Reset
REQ-022 rst=0 SHALL force state IDLE, counter 0, div_done_o=0, div_result_o=64'h0, all operand registers 0.
REQ-023 Reset asserted mid-CALC or in DONE SHALL abort the operation immediately; no done pulse after release.
REQ-024 After rst returns high, the block SHALL accept div_start_i on the first rising edge.

Configuration
REQ-025 Macro DIV_ZERO_SHORTCUT_EN: when defined, divisor zero SHALL go IDLE->DONE directly, div_done_o high in cycle 1 with REQ-016 result.
REQ-026 Without DIV_ZERO_SHORTCUT_EN, divisor zero SHALL run the full 32-step CALC, done in cycle 33, result forced per REQ-016.

Verification
REQ-027 Unsigned 100/7, start held -> done cycle 33, div_result_o = {0x00000002, 0x0000000E}.
REQ-028 Signed 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
REQ-029 0x12345678 / 0 (signed and unsigned) -> {0x12345678, 0xFFFFFFFF}; done cycle 1 with DIV_ZERO_SHORTCUT_EN, cycle 33 without.
REQ-030 Start 50/5, drop div_start_i at cycle 10 -> no done, IDLE next cycle; then unsigned 9/3 -> {0x00000000, 0x00000003} at cycle 33 of the new request.
REQ-031 rst low at cycle 20 of an operation -> div_done_o=0, div_result_o=0 immediately, no done after release.
REQ-032 Hold div_start_i high 3 cycles past done -> div_done_o stays high with stable result; IDLE one edge after start drops.
